// File: rtl/uart_pkg.sv
// Shared types and constants for the word-wide UART transmitter.
// Frame: start bit, 8 data bits LSB first, stop bit.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

  localparam int   OVERSAMPLE    = 16;
  localparam int   BITS_PER_BYTE = 8;
  localparam logic START_BIT     = 1'b0;
  localparam logic STOP_BIT      = 1'b1;

endpackage

// File: rtl/uart_word_tx.sv
// Word-wide UART transmitter: sends DATA_WIDTH/8 framed bytes,
// low byte first, paced by an external 16x-baud clken tick.
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clken,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid,
  output logic                  ready,
  output logic                  tx
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [3:0]    TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(BITS_PER_BYTE - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(NBYTES - 1);

  uart_tx_state_t        state_q;
  logic [3:0]            tick_q;
  logic [2:0]            bit_q;
  logic [BW-1:0]         byte_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  tx_q;
  logic                  ready_q;

  logic [3:0]            tick_d;
  logic [DATA_WIDTH-1:0] shift_d;
  logic                  bit_end;
  logic                  accept;

  always_comb begin
    tick_d  = tick_q + 4'd1;
    shift_d = shift_q >> 1;
    bit_end = clken && (tick_q == TICK_LAST);
    accept  = valid && ready_q;
  end

  // Whole word shifts right once per data bit, so the next
  // byte lands in the low bits without a byte mux.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shift_q <= '0;
      tx_q    <= STOP_BIT;
      ready_q <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            shift_q <= data_in;
            tick_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            tx_q    <= START_BIT;
            ready_q <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (clken) tick_q <= tick_d;
          if (bit_end) begin
            tick_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          if (clken) tick_q <= tick_d;
          if (bit_end) begin
            tick_q  <= '0;
            bit_q   <= bit_q + 3'd1;
            shift_q <= shift_d;
            if (bit_q == BIT_LAST) begin
              tx_q    <= STOP_BIT;
              state_q <= STOP;
            end else begin
              tx_q <= shift_q[1];
            end
          end
        end
        STOP: begin
          if (clken) tick_q <= tick_d;
          if (bit_end) begin
            tick_q <= '0;
            if (byte_q == BYTE_LAST) begin
              byte_q  <= '0;
              tx_q    <= STOP_BIT;
              ready_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              byte_q  <= byte_q + 1'b1;
              tx_q    <= START_BIT;
              state_q <= START;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx    = tx_q;
  assign ready = ready_q;

endmodule
